// File: rtl/prog_loader_pkg.sv
// Shared constants and state encoding for the boot-time program loader and the CPU top.
package prog_loader_pkg;

    localparam logic [7:0]  SYNC_BYTE  = 8'hA5;
    localparam int unsigned RAM_ADDR_W = 11;
    localparam int unsigned RAM_DEPTH  = 2048;
    localparam int unsigned RAM_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

endpackage

// File: rtl/prog_loader_idle_timer.sv
// Counts idle cycles while a frame is open; restarts on every accepted byte.
module idle_timer #(
    parameter int unsigned TIMEOUT = 16000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    input  logic i_kick,
    output logic o_expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!i_run || i_kick) begin
            r_cnt <= '0;
        end else if (!o_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (r_cnt == CNT_W'(TIMEOUT));

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses sync/length/data/checksum frames and writes
// 32-bit words into instruction RAM while holding the CPU.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_W  = RAM_ADDR_W,
    parameter int unsigned DEPTH   = RAM_DEPTH,
    parameter int unsigned TIMEOUT = 16000
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [RAM_DATA_W-1:0] ram_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_err,
    output logic [ADDR_W:0]       words_loaded
);

    state_t                r_state;
    state_t                w_next;
    logic                  w_accept;
    logic                  w_expired;
    logic                  w_in_frame;
    logic                  w_last_word;
    logic [15:0]           w_len;
    logic [7:0]            r_len_hi;
    logic [15:0]           r_count;
    logic [1:0]            r_byte_idx;
    logic [23:0]           r_shift;
    logic [7:0]            r_csum;
    logic [ADDR_W:0]       r_words;
    logic                  r_ram_we;
    logic [ADDR_W-1:0]     r_ram_addr;
    logic [RAM_DATA_W-1:0] r_ram_wdata;
    logic                  r_cpu_hold;
    logic                  r_load_err;

    assign rx_ready    = (r_state != ST_DONE) && (r_state != ST_ERR);
    assign w_accept    = rx_valid && rx_ready;
    assign w_in_frame  = (r_state == ST_LEN_HI) || (r_state == ST_LEN_LO) ||
                         (r_state == ST_DATA)   || (r_state == ST_CSUM);
    assign w_len       = {r_len_hi, rx_data};
    // The previous word's write has always retired before the next 4th byte arrives.
    assign w_last_word = ((32'(r_words) + 32'd1) == 32'(r_count));

    idle_timer #(.TIMEOUT(TIMEOUT)) u_idle_timer (
        .i_clk     (CLK),
        .i_rst_n   (RST_N),
        .i_run     (w_in_frame),
        .i_kick    (w_accept),
        .o_expired (w_expired)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept && rx_data == SYNC_BYTE) w_next = ST_LEN_HI;
            ST_LEN_HI: if (w_accept) w_next = ST_LEN_LO;
            ST_LEN_LO: begin
                if (w_accept) begin
                    if (w_len == 16'd0)             w_next = ST_CSUM;
                    else if (32'(w_len) > DEPTH)    w_next = ST_ERR;
                    else                            w_next = ST_DATA;
                end
            end
            ST_DATA:   if (w_accept && r_byte_idx == 2'd3 && w_last_word) w_next = ST_CSUM;
            ST_CSUM:   if (w_accept) w_next = (rx_data == r_csum) ? ST_DONE : ST_ERR;
            ST_DONE:   w_next = ST_IDLE;
            ST_ERR:    w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
        if (w_in_frame && w_expired && !w_accept) w_next = ST_ERR;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_len_hi    <= '0;
            r_count     <= '0;
            r_byte_idx  <= '0;
            r_shift     <= '0;
            r_csum      <= '0;
            r_words     <= '0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_cpu_hold  <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_ram_we <= 1'b0;
            if (r_ram_we) r_words <= r_words + 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && rx_data == SYNC_BYTE) begin
                        r_cpu_hold <= 1'b1;
                        r_load_err <= 1'b0;
                        r_words    <= '0;
                        r_csum     <= '0;
                        r_byte_idx <= '0;
                    end
                end
                ST_LEN_HI: if (w_accept) r_len_hi <= rx_data;
                ST_LEN_LO: if (w_accept) r_count <= w_len;
                ST_DATA: begin
                    if (w_accept) begin
                        r_csum     <= r_csum ^ rx_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        r_shift    <= {r_shift[15:0], rx_data};
                        if (r_byte_idx == 2'd3) begin
                            r_ram_we    <= 1'b1;
                            r_ram_addr  <= r_words[ADDR_W-1:0];
                            r_ram_wdata <= {r_shift, rx_data};
                        end
                    end
                end
                ST_DONE: r_cpu_hold <= 1'b0;
                ST_ERR:  r_load_err <= 1'b1;
                default: ;
            endcase
        end
    end

    assign ram_we       = r_ram_we;
    assign ram_addr     = r_ram_addr;
    assign ram_wdata    = r_ram_wdata;
    assign cpu_hold     = r_cpu_hold;
    assign load_done    = (r_state == ST_DONE);
    assign load_err     = r_load_err;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized frame stimulus for prog_loader checked against a frame-level reference model.
module tb_prog_loader;

    localparam int unsigned TO = 50;

    logic        CLK;
    logic        RST_N;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        ram_we;
    logic [10:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [11:0] words_loaded;

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;
    int unsigned done_cnt = 0;
    int unsigned wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] model_words[$];

    prog_loader #(.ADDR_W(11), .DEPTH(2048), .TIMEOUT(TO)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (ram_we) begin
            wr_addr_q.push_back(int'(ram_addr));
            wr_data_q.push_back(ram_wdata);
        end
        if (load_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap_max);
        int unsigned waited = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && waited < 100) begin
            idle(1);
            waited++;
        end
        if (!rx_ready) check("rdy_wait", rx_ready, 1);
        @(posedge CLK);
        #1;
        rx_valid = 1'b0;
        if (gap_max > 0) idle($urandom_range(0, gap_max));
    endtask

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    // Frame-level model: every declared word lands at its index, checksum decides the outcome.
    task automatic play_frame(input string tag, input bit corrupt, input int unsigned gap_max);
        int unsigned n;
        int unsigned done0;
        logic [15:0] n16;
        logic [7:0]  cs;
        logic [31:0] w;
        n     = model_words.size();
        n16   = 16'(n);
        done0 = done_cnt;
        cs    = 8'h00;
        clear_mon();
        send_byte(8'hA5, gap_max);
        send_byte(n16[15:8], gap_max);
        send_byte(n16[7:0], gap_max);
        for (int i = 0; i < int'(n); i++) begin
            w = model_words[i];
            for (int b = 3; b >= 0; b--) begin
                cs = cs ^ w[8*b +: 8];
                send_byte(w[8*b +: 8], gap_max);
            end
        end
        send_byte(corrupt ? (cs ^ 8'h01) : cs, 0);
        idle(4);
        check({tag, "_nwr"}, wr_addr_q.size(), n);
        for (int i = 0; i < int'(n); i++) begin
            if (i < int'(wr_addr_q.size())) begin
                check({tag, "_addr"}, wr_addr_q[i], i);
                check({tag, "_data"}, wr_data_q[i], model_words[i]);
            end
        end
        check({tag, "_done"}, done_cnt - done0, corrupt ? 0 : 1);
        check({tag, "_err"}, load_err, corrupt);
        check({tag, "_hold"}, cpu_hold, corrupt);
        check({tag, "_words"}, words_loaded, n);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rdy"},   rx_ready, 1);
        check({tag, "_we"},    ram_we, 0);
        check({tag, "_addr"},  ram_addr, 0);
        check({tag, "_wdata"}, ram_wdata, 0);
        check({tag, "_hold"},  cpu_hold, 0);
        check({tag, "_done"},  load_done, 0);
        check({tag, "_err"},   load_err, 0);
        check({tag, "_words"}, words_loaded, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int unsigned done0;
        int unsigned nw;
        bit          bad;

        RST_N    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #22;
        check_reset_vals("rst");
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        idle(2);

        model_words = '{32'h60000003, 32'h20000001};
        play_frame("good2", 1'b0, 0);

        model_words.delete();
        play_frame("empty", 1'b0, 0);

        model_words = '{32'h60000003, 32'h20000001};
        play_frame("badcs", 1'b1, 0);

        model_words = '{32'hA500A5A5, 32'h00A50001, 32'h12345678};
        play_frame("a5data", 1'b0, 1);

        done0 = done_cnt;
        clear_mon();
        send_byte(8'hA5, 0);
        send_byte(8'h08, 0);
        send_byte(8'h01, 0);
        idle(4);
        check("big_nwr", wr_addr_q.size(), 0);
        check("big_err", load_err, 1);
        check("big_hold", cpu_hold, 1);
        check("big_words", words_loaded, 0);
        check("big_done", done_cnt - done0, 0);
        model_words = '{32'hDEADBEEF};
        play_frame("recover", 1'b0, 0);

        clear_mon();
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        idle(TO - 3);
        check("to_early", load_err, 0);
        for (int i = 0; i < 20 && !load_err; i++) idle(1);
        check("to_err", load_err, 1);
        check("to_hold", cpu_hold, 1);
        check("to_nwr", wr_addr_q.size(), 0);

        clear_mon();
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h60, 0);
        send_byte(8'h00, 0);
        #2;
        RST_N = 1'b0;
        #1;
        check_reset_vals("midrst");
        idle(2);
        RST_N = 1'b1;
        idle(1);
        send_byte(8'h60, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        idle(3);
        check("post_nwr", wr_addr_q.size(), 0);
        check("post_hold", cpu_hold, 0);
        check("post_words", words_loaded, 0);

        for (int f = 0; f < 20; f++) begin
            nw  = $urandom_range(0, 6);
            bad = ($urandom_range(0, 3) == 0);
            model_words.delete();
            for (int i = 0; i < int'(nw); i++) model_words.push_back($urandom);
            play_frame("rnd", bad, 3);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, meaning instruction-RAM word-address width.
REQ-002 SHALL have parameter DEPTH, default 2048, meaning maximum loadable words.
REQ-003 SHALL have parameter TIMEOUT, default 16000, meaning maximum idle cycles between bytes mid-frame (1 ms at 16 MHz).
REQ-004 SHALL have port CLK  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port RST_N  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port rx_data  in  8  incoming byte.
REQ-007 SHALL have port rx_valid  in  1  rx_data valid.
REQ-008 SHALL have port rx_ready  out  1  loader accepts byte; a transfer occurs when rx_valid and rx_ready are both high on a rising edge.
REQ-009 SHALL have port ram_we  out  1  instruction-RAM write strobe, one cycle per word.
REQ-010 SHALL have port ram_addr  out  ADDR_W  write word address.
REQ-011 SHALL have port ram_wdata  out  32  write word.
REQ-012 SHALL have port cpu_hold  out  1  holds the CPU fetch engine (pc 0, phase 0) while high.
REQ-013 SHALL have port load_done  out  1  one-cycle pulse on successful load.
REQ-014 SHALL have port load_err  out  1  sticky error flag.
REQ-015 SHALL have port words_loaded  out  ADDR_W+1  count of words written in the current or last frame.

Function
REQ-016 SHALL implement frame format: sync 0xA5, count_hi, count_lo (word count N, big-endian), 4*N data bytes (each word big-endian, MSB first), checksum byte = XOR of all 4*N data bytes.
REQ-017 SHALL implement states: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR.
REQ-018 SHALL, in IDLE, discard every byte except 0xA5; 0xA5 moves to LEN_HI, sets cpu_hold, clears load_err, zeroes words_loaded and checksum.
REQ-019 SHALL move LEN_HI->LEN_LO->DATA on accepted bytes; if N==0, LEN_LO goes to CSUM; if N>DEPTH, LEN_LO goes to ERR.
REQ-020 SHALL, in DATA, assemble bytes with a 2-bit byte index; the cycle after the 4th byte, ram_we=1 with ram_addr=words_loaded and the assembled word (1-cycle write latency); words_loaded then increments.
REQ-021 SHALL go DATA->CSUM when the 4th byte of word N-1 is accepted.
REQ-022 SHALL, in CSUM, compare the byte to the running XOR: match -> DONE, mismatch -> ERR.
REQ-023 SHALL, in DONE, pulse load_done for one cycle, clear cpu_hold, and return to IDLE.
REQ-024 SHALL, in ERR, set load_err, keep cpu_hold high (a partial program never runs), and return to IDLE; only a later successful frame clears cpu_hold.
REQ-025 SHALL hold rx_ready high in IDLE, LEN_HI, LEN_LO, DATA and CSUM, and low in DONE and ERR.
REQ-026 SHALL, in any state other than IDLE, DONE or ERR, count cycles without an accepted byte, reload on each accepted byte, and go to ERR when the count reaches TIMEOUT.
REQ-027 SHALL treat 0xA5 inside a frame as ordinary data (no resync).
REQ-028 SHALL hold ram_we low at all times except the write cycle of REQ-020.

Reset
REQ-029 SHALL, while RST_N is low, force state IDLE, rx_ready=1, ram_we=0, ram_addr=0, ram_wdata=0, cpu_hold=0, load_done=0, load_err=0, words_loaded=0, and clear the timeout counter and checksum.
REQ-030 SHALL abort a frame in progress on reset assertion, issuing no further RAM writes.

Structure
REQ-031 SHALL place the sync byte value (0xA5), the state enumeration and the RAM depth/width constants in a shared package used by the CPU top.
REQ-032 SHALL be one module; the timeout counter MAY be a sub-module named idle_timer.

Verification
REQ-033 SHALL send A5 00 02 60 00 00 03 20 00 00 01 then checksum 0x42 -> ram_we at addr 0 with data 0x60000003 and at addr 1 with data 0x20000001; load_done pulses; cpu_hold falls; words_loaded=2.
REQ-034 SHALL send A5 00 00 00 -> no RAM write; load_done pulses; words_loaded=0.
REQ-035 SHALL send the REQ-033 frame with checksum 0x43 -> both words written; load_err=1; cpu_hold stays 1; no load_done.
REQ-036 SHALL send A5 08 01 -> ERR (N=2049 > DEPTH), no writes; then send a good frame -> load_err clears, cpu_hold falls.
REQ-037 SHALL send A5 00 01 12 then hold rx_valid low for TIMEOUT cycles -> load_err=1; no ram_we.
REQ-038 SHALL assert RST_N low mid-DATA -> state IDLE, all outputs at reset values, and the next byte 0x60 is ignored.
